// File: rtl/bfu_v2_if.sv
// Beat-level bus of the bfu_v2 NTT butterfly: input beat, quasi-static modulus
// constants and result beat, each direction with its own valid/ready pair.
`timescale 1ns/1ps
interface bfu_v2_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   mu;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;

    modport master (
        output in_valid, mode, a, b, w, p, mu, out_ready,
        input  in_ready, out_valid, out1, out2
    );

    modport slave (
        input  in_valid, mode, a, b, w, p, mu, out_ready,
        output in_ready, out_valid, out1, out2
    );
endinterface

// File: rtl/bfu_v2.sv
// Pipelined modular butterfly (CT / GS / GS_HALF / PWM) with Barrett reduction
// and whole-pipeline stall. Define BFU_V2_HALVE_EN to enable halving in mode 2.
`timescale 1ns/1ps
module bfu_v2 #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    bfu_v2_if.slave bus
);
    localparam int LATENCY = 5;

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
        return sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] diff;
        diff = {1'b0, x} - {1'b0, y};
        if (x < y) diff = diff + {1'b0, m};
        return diff[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] reduce_3p(input logic [WIDTH+1:0] r,
                                                   input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] v;
        v = r;
        if (v >= {2'b00, m}) v = v - {2'b00, m};
        if (v >= {2'b00, m}) v = v - {2'b00, m};
        return v[WIDTH-1:0];
    endfunction

`ifdef BFU_V2_HALVE_EN
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] v;
        v = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
        return v[WIDTH:1];
    endfunction
`endif

    logic               adv;
    logic               accept;
    logic [LATENCY:0]   vld_p;
    logic [WIDTH-1:0]   s_c, d_c, x_c;
    logic [1:0]         mode_p0, mode_p1, mode_p2, mode_p3, mode_p4;
    logic [WIDTH-1:0]   a_p0, a_p1, a_p2, a_p3, a_p4;
    logic [WIDTH-1:0]   s_p0, s_p1, s_p2, s_p3, s_p4;
    logic [WIDTH-1:0]   x_p0, w_p0;
    logic [2*WIDTH-1:0] prod_p1;
    logic [2*WIDTH+1:0] qm_c;
    logic [WIDTH:0]     q_p2;
    logic [WIDTH+1:0]   prod_lo_p2;
    logic [2*WIDTH:0]   qp_c;
    logic [WIDTH+1:0]   r_p3;
    logic [WIDTH-1:0]   t_p4;
    logic               unused_bits;

    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;
    assign accept       = bus.in_valid & adv;
    assign bus.out_valid = vld_p[LATENCY];

    assign s_c = add_mod(bus.a, bus.b, bus.p);
    assign d_c = sub_mod(bus.a, bus.b, bus.p);
    assign x_c = (bus.mode == 2'd1 || bus.mode == 2'd2) ? d_c : bus.b;

    // Barrett: quotient estimate from the product top bits, then r = prod - q*p.
    // The remainder only needs WIDTH+2 bits since r < 3p.
    assign qm_c = prod_p1[2*WIDTH-1:WIDTH-1] * bus.mu;
    assign qp_c = q_p2 * bus.p;
    assign unused_bits = ^{qm_c[WIDTH:0], qp_c[2*WIDTH:WIDTH+2]};

    always_ff @(posedge clk) begin
        if (adv) begin
            // S0: input register
            a_p0    <= bus.a;
            s_p0    <= s_c;
            x_p0    <= x_c;
            w_p0    <= bus.w;
            mode_p0 <= bus.mode;
            // S1: full product
            a_p1    <= a_p0;
            s_p1    <= s_p0;
            mode_p1 <= mode_p0;
            prod_p1 <= x_p0 * w_p0;
            // S2a: Barrett quotient, registered to split the two multiplies
            a_p2       <= a_p1;
            s_p2       <= s_p1;
            mode_p2    <= mode_p1;
            q_p2       <= qm_c[2*WIDTH+1:WIDTH+1];
            prod_lo_p2 <= prod_p1[WIDTH+1:0];
            // S2b: Barrett remainder
            a_p3    <= a_p2;
            s_p3    <= s_p2;
            mode_p3 <= mode_p2;
            r_p3    <= prod_lo_p2 - qp_c[WIDTH+1:0];
            // S3: final correction to t = x*w mod p
            a_p4    <= a_p3;
            s_p4    <= s_p3;
            mode_p4 <= mode_p3;
            t_p4    <= reduce_3p(r_p3, bus.p);
        end
    end

    // S4: output register; only valid beats update the visible result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p    <= '0;
            bus.out1 <= '0;
            bus.out2 <= '0;
        end else if (adv) begin
            vld_p <= {vld_p[LATENCY-1:0], accept};
            if (vld_p[LATENCY-1]) begin
                case (mode_p4)
                    2'd0: begin
                        bus.out1 <= add_mod(a_p4, t_p4, bus.p);
                        bus.out2 <= sub_mod(a_p4, t_p4, bus.p);
                    end
                    2'd1: begin
                        bus.out1 <= s_p4;
                        bus.out2 <= t_p4;
                    end
                    2'd2: begin
`ifdef BFU_V2_HALVE_EN
                        bus.out1 <= half_mod(s_p4, bus.p);
                        bus.out2 <= half_mod(t_p4, bus.p);
`else
                        bus.out1 <= s_p4;
                        bus.out2 <= t_p4;
`endif
                    end
                    default: begin
                        bus.out1 <= t_p4;
                        bus.out2 <= a_p4;
                    end
                endcase
            end
        end
    end
endmodule
